// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: button FSM states and default
// cycle counts derived from the system clock frequency.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_t;

  localparam int CLK_FREQ_HZ        = 50_000_000;
  localparam int LONG_PRESS_CYCLES  = CLK_FREQ_HZ;      // 1 s
  localparam int REPEAT_PRESS_CYCLES = CLK_FREQ_HZ / 5; // 200 ms

endpackage

// File: rtl/button_press_ctrl.sv
// Turns debounced button activity into short-press, long-press and
// auto-repeat single-cycle strobes; all outputs are registered.
module button_press_ctrl
  import clock_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES = REPEAT_PRESS_CYCLES,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic btn_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  generate
    if (LONG_CYCLES < 2) begin : g_bad_long
      $error("button_press_ctrl: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("button_press_ctrl: REPEAT_CYCLES must be >= 1");
    end
  endgenerate

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             held_q, held_d;

  // Release is tested first in every timing state so it wins over terminal counts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_pulse) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TC) begin
          long_d  = 1'b1;
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_TC) begin
          cnt_d = '0;
          rep_d = REPEAT_EN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = rep_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_press_ctrl.sv
// Directed bench for button_press_ctrl with LONG_CYCLES=20, REPEAT_CYCLES=5.
module tb_button_press_ctrl;

  localparam int LONG = 20;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_level = 1'b0;
  logic btn_pulse = 1'b0;

  logic s1, l1, r1, h1;
  logic s0, l0, r0, h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  button_press_ctrl #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .short_pulse(s1), .long_pulse(l1), .repeat_pulse(r1), .held(h1)
  );

  button_press_ctrl #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .short_pulse(s0), .long_pulse(l0), .repeat_pulse(r0), .held(h0)
  );

  // exp packs {short, long, repeat, held} after the edge that samples the inputs
  typedef struct {
    logic       pulse;
    logic       level;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {short,long,rep,held}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    btn_level = 1'b0;
    btn_pulse = 1'b0;
    repeat (n) tick();
  endtask

  task automatic press_e0();
    btn_pulse = 1'b1;
    btn_level = 1'b1;
    tick();
    btn_pulse = 1'b0;
  endtask

  initial begin
    // Reset state
    #5 rst_n = 1'b0;
    #1 chk("reset_async", {s1, l1, r1, h1}, 4'b0000);
    repeat (2) tick();
    chk("reset_held", {s1, l1, r1, h1}, 4'b0000);
    chk("reset_nr", {s0, l0, r0, h0}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // Table: short press of 10 held cycles, level-only activity, then a minimal press
    vecs.push_back('{1'b1, 1'b1, 4'b0001});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b1, 4'b0001});
    vecs.push_back('{1'b0, 1'b0, 4'b1000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 4'b0000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, 4'b0001});
    vecs.push_back('{1'b0, 1'b0, 4'b1000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000});
    for (int i = 0; i < vecs.size(); i++) begin
      btn_pulse = vecs[i].pulse;
      btn_level = vecs[i].level;
      tick();
      chk($sformatf("table[%0d]", i), {s1, l1, r1, h1}, vecs[i].exp);
    end
    idle(2);

    // Long press with repeat (and REPEAT_EN=0 instance in parallel)
    press_e0();
    chk("long_e0_held", {s1, l1, r1, h1}, 4'b0001);
    for (int k = 1; k <= 40; k++) begin
      logic el, er;
      tick();
      el = (k == LONG);
      er = (k > LONG) && (((k - LONG) % REP) == 0);
      chk($sformatf("long k=%0d", k), {s1, l1, r1, h1}, {1'b0, el, er, 1'b1});
      chk($sformatf("norep k=%0d", k), {s0, l0, r0, h0}, {1'b0, el, 1'b0, 1'b1});
    end
    btn_level = 1'b0;
    tick();
    chk("long_release", {s1, l1, r1, h1}, 4'b0000);
    chk("norep_release", {s0, l0, r0, h0}, 4'b0000);
    idle(2);

    // Release sampled on the long terminal edge: short wins
    press_e0();
    for (int k = 1; k < LONG; k++) tick();
    chk("term_pre", {s1, l1, r1, h1}, 4'b0001);
    btn_level = 1'b0;
    tick();
    chk("term_release", {s1, l1, r1, h1}, 4'b1000);
    tick();
    chk("term_after", {s1, l1, r1, h1}, 4'b0000);
    idle(2);

    // Release on a repeat terminal edge: no repeat strobe
    press_e0();
    for (int k = 1; k < LONG + REP; k++) tick();
    btn_level = 1'b0;
    tick();
    chk("rep_term_release", {s1, l1, r1, h1}, 4'b0000);
    idle(2);

    // Reset mid-press, button still held afterwards
    press_e0();
    for (int k = 1; k <= 12; k++) tick();
    chk("pre_reset_held", {s1, l1, r1, h1}, 4'b0001);
    rst_n = 1'b0;
    #1 chk("reset_mid_press", {s1, l1, r1, h1}, 4'b0000);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
        tick();
        if ({s1, l1, r1, h1} !== 4'b0000) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: %0d active cycles, expected 0", bad);
      end
    end
    idle(2);

    // Spurious btn_pulse in PRESSED at E0+5 is ignored
    press_e0();
    for (int k = 1; k <= LONG; k++) begin
      btn_pulse = (k == 5);
      tick();
      chk($sformatf("spur k=%0d", k), {s1, l1, r1, h1}, {1'b0, (k == LONG), 1'b0, 1'b1});
    end
    btn_pulse = 1'b0;
    btn_level = 1'b0;
    tick();
    chk("spur_release", {s1, l1, r1, h1}, 4'b0000);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
